// File: rtl/punc_mem_pkg.sv
// Shared definitions for the PUnC memory arbiter.
// Holds the FSM state encodings, requester index constants and a helper
// that expands a requester index into a one-hot {dbg, dm, if} vector.
package punc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [1:0] REQ_IF  = 2'd0;
  localparam logic [1:0] REQ_DM  = 2'd1;
  localparam logic [1:0] REQ_DBG = 2'd2;

  // Bit order of the result is {dbg, dm, if}; an unused index gives no bit.
  function automatic logic [2:0] owner_onehot(input logic [1:0] idx);
    logic [2:0] vec;
    case (idx)
      REQ_IF:  vec = 3'b001;
      REQ_DM:  vec = 3'b010;
      REQ_DBG: vec = 3'b100;
      default: vec = 3'b000;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/punc_mem_arbiter_if.sv
// Requester-side bundle of the PUnC memory arbiter.
// master: the requesters (fetch, data, debug) drive req/addr/we/wdata/lock
//         and receive gnt/rvalid pulses plus the shared rdata and busy.
// slave:  the arbiter, mirror image of master.
interface punc_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic              dm_req;
  logic              dbg_req;
  logic [ADDR_W-1:0] if_addr;
  logic [ADDR_W-1:0] dm_addr;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dm_we;
  logic              dbg_we;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dm_lock;
  logic              if_gnt;
  logic              dm_gnt;
  logic              dbg_gnt;
  logic              if_rvalid;
  logic              dm_rvalid;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output if_req, dm_req, dbg_req, if_addr, dm_addr, dbg_addr,
           dm_we, dbg_we, dm_wdata, dbg_wdata, dm_lock,
    input  if_gnt, dm_gnt, dbg_gnt, if_rvalid, dm_rvalid, dbg_rvalid,
           rdata, busy
  );

  modport slave (
    input  if_req, dm_req, dbg_req, if_addr, dm_addr, dbg_addr,
           dm_we, dbg_we, dm_wdata, dbg_wdata, dm_lock,
    output if_gnt, dm_gnt, dbg_gnt, if_rvalid, dm_rvalid, dbg_rvalid,
           rdata, busy
  );
endinterface

// File: rtl/punc_mem_prio_sel.sv
// Fixed-priority winner picker (dbg > dm > if) with lock override.
// Ports: if_req/dm_req/dbg_req request lines, locked (memory reserved for
// the data port); win_valid says a winner exists, win_idx is its index.
module punc_mem_prio_sel
  import punc_mem_pkg::*;
(
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       dbg_req,
  input  logic       locked,
  output logic       win_valid,
  output logic [1:0] win_idx
);

  // Pick the highest-priority requester; while locked only dm may win
  always_comb begin
    win_valid = 1'b0;
    win_idx   = REQ_IF;
    if (locked) begin
      if (dm_req) begin
        win_valid = 1'b1;
        win_idx   = REQ_DM;
      end else begin
        win_valid = 1'b0;
      end
    end else if (dbg_req) begin
      win_valid = 1'b1;
      win_idx   = REQ_DBG;
    end else if (dm_req) begin
      win_valid = 1'b1;
      win_idx   = REQ_DM;
    end else if (if_req) begin
      win_valid = 1'b1;
      win_idx   = REQ_IF;
    end else begin
      win_valid = 1'b0;
    end
  end

endmodule

// File: rtl/punc_mem_arbiter.sv
// Sequencer/arbiter for the single-port PUnC LC3 memory.
// Ports: clk, rst (async, active-low); bus (slave side of the requester
// bundle); mem_addr/mem_we/mem_wdata drive the memory, mem_rdata is its
// synchronous read port (valid the cycle after mem_addr).
// Every access is IDLE (arbitrate + latch) -> ACCESS (gnt) -> RESP (rvalid,
// reads only). gnt/rvalid/busy/mem_we decode directly from flops, so there
// is no combinational path from any req to any output.
module punc_mem_arbiter
  import punc_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
)(
  input  logic               clk,
  input  logic               rst,
  punc_mem_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
);

  state_e            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              locked_q, locked_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              win_valid_s;
  logic [1:0]        win_idx_s;
  logic [2:0]        gnt_vec_s;
  logic [2:0]        rvalid_vec_s;

  punc_mem_prio_sel u_prio_sel (
    .if_req    (bus.if_req),
    .dm_req    (bus.dm_req),
    .dbg_req   (bus.dbg_req),
    .locked    (locked_q),
    .win_valid (win_valid_s),
    .win_idx   (win_idx_s)
  );

  // Next-state logic and request latching
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    locked_d = locked_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (win_valid_s) begin
          owner_d = win_idx_s;
          state_d = ACCESS;
          case (win_idx_s)
            REQ_DBG: begin
              addr_d  = bus.dbg_addr;
              we_d    = bus.dbg_we;
              wdata_d = bus.dbg_wdata;
            end
            REQ_DM: begin
              addr_d   = bus.dm_addr;
              we_d     = bus.dm_we;
              wdata_d  = bus.dm_wdata;
              // Only a data-port grant can take or release the reservation
              locked_d = bus.dm_lock;
            end
            default: begin
              // Fetch is read-only; keep the previous write data on the bus
              addr_d = bus.if_addr;
              we_d   = 1'b0;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        rdata_d = mem_rdata;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and read-data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= REQ_IF;
      addr_q   <= {ADDR_W{1'b0}};
      we_q     <= 1'b0;
      wdata_q  <= {DATA_W{1'b0}};
      locked_q <= 1'b0;
      rdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      locked_q <= locked_d;
      rdata_q  <= rdata_d;
    end
  end

  // Grant and read-valid pulses decoded from state and owner flops
  always_comb begin
    gnt_vec_s    = 3'b000;
    rvalid_vec_s = 3'b000;
    case (state_q)
      ACCESS:  gnt_vec_s    = owner_onehot(owner_q);
      RESP:    rvalid_vec_s = owner_onehot(owner_q);
      default: begin
        gnt_vec_s    = 3'b000;
        rvalid_vec_s = 3'b000;
      end
    endcase
  end

  assign bus.if_gnt     = gnt_vec_s[0];
  assign bus.dm_gnt     = gnt_vec_s[1];
  assign bus.dbg_gnt    = gnt_vec_s[2];
  assign bus.if_rvalid  = rvalid_vec_s[0];
  assign bus.dm_rvalid  = rvalid_vec_s[1];
  assign bus.dbg_rvalid = rvalid_vec_s[2];
  assign bus.busy       = (state_q != IDLE);

  // The memory read port is itself a register, so passing it through in RESP
  // presents the word alongside rvalid; rdata_q keeps it afterwards.
  assign bus.rdata = (state_q == RESP) ? mem_rdata : rdata_q;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = (state_q == ACCESS) && we_q;

endmodule

// File: doc/punc_mem_arbiter.md
# punc_mem_arbiter

Sequencer and arbiter for the single-port PUnC LC3 memory. Shares the memory between three requesters: instruction fetch (control FSM), data load/store (datapath, including LDI/STI/JSRR-style back-to-back accesses), and debug. Each access runs as a registered grant → access → read-response sequence. It sits between PUnCControl/PUnCDatapath and the memory and owns every memory address, write-enable and write-data signal.

## Interface

- ADDR_W, 16, memory address width
- DATA_W, 16, memory word width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- if_req, dm_req, dbg_req  in  1 each  access request; held with its addr/we/wdata until the matching gnt
- if_addr, dm_addr, dbg_addr  in  ADDR_W each  request address
- dm_we, dbg_we  in  1 each  1 = write; fetch is always a read
- dm_wdata, dbg_wdata  in  DATA_W each  write data
- dm_lock  in  1  sampled with dm_req at grant; keeps the memory reserved for the data port's next access
- if_gnt, dm_gnt, dbg_gnt  out  1 each  one-cycle grant pulse
- if_rvalid, dm_rvalid, dbg_rvalid  out  1 each  one-cycle read-data-valid pulse
- rdata  out  DATA_W  read data, shared by all requesters
- busy  out  1  state ≠ IDLE
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, synchronous, valid the cycle after mem_addr

## Operation

- FSM states are IDLE, ACCESS and RESP.
- **IDLE:** sample requests and pick a winner.
  - Priority is dbg > dm > if.
  - If `locked`=1, only dm_req can win; the arbiter waits indefinitely with the others blocked.
  - With no winner, stay in IDLE.
  - With a winner, latch its owner, addr, we (forced 0 for if) and wdata, then go to ACCESS.
- **ACCESS:** the owner's gnt=1.
  - mem_addr comes from the latched addr.
  - mem_we = latched we.
  - A read goes to RESP; a write goes to IDLE.
- **RESP:** rdata ← mem_rdata, registered. The owner's rvalid=1. Go to IDLE.
- **Lock:**
  - `locked` is set when dm is granted with dm_lock=1.
  - It is cleared when dm is granted with dm_lock=0.
  - It is never set by if or dbg.
- rdata holds the last read value until the next RESP.
- mem_addr and mem_wdata hold their latched values in IDLE. mem_we is 0 outside ACCESS.
- Requester rule: deassert req the cycle after seeing gnt. If req is still high in IDLE, that is a new request.
- **Reset (rst=0, any time):** immediately forces:
  - state=IDLE and locked=0
  - all gnt, all rvalid, busy and mem_we = 0
  - mem_addr, mem_wdata and rdata = 0

  A write in flight is aborted: mem_we drops asynchronously.

## Timing

- Read: req sampled in IDLE at cycle N → gnt and memory access at N+1 → rvalid and rdata at N+2 → IDLE at N+3. Each read takes 3 cycles.
- Write: req at N → gnt and mem_we=1 at N+1 → IDLE at N+2. Each write takes 2 cycles.
- gnt, rvalid and busy are registered (driven from state/owner flops). There is no combinational path from req to gnt.
- Simultaneous requests are resolved in one IDLE cycle by priority. A loser keeps req high and wins a later IDLE.
- A request that arrives during ACCESS or RESP is ignored until the next IDLE.

## Structure

- Shared package `punc_mem_pkg` holds:
  - state encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2
  - requester index constants REQ_IF=2'd0, REQ_DM=2'd1, REQ_DBG=2'd2
- One sub-module, `punc_mem_prio_sel`: combinational fixed-priority picker with lock override. Inputs are the three req lines and locked; outputs are a winner-valid bit and a winner index.
- FSM, latches and output muxing live in the top level.

## Test plan

- Fetch read: if_req=1, if_addr=16'h3000, mem[3000]=16'h1234. Expect if_gnt at N+1 with mem_addr=3000 and mem_we=0, then if_rvalid=1 and rdata=1234 at N+2.
- Data write: dm_req=1, dm_we=1, dm_addr=16'h4001, dm_wdata=16'hBEEF. Expect dm_gnt with mem_we=1 for exactly one cycle at N+1. A later fetch read of 4001 returns BEEF.
- Contention: if_req, dm_req and dbg_req asserted together with each held until granted. Expect grants in the order dbg, dm, if, with no cycle where two gnts are high.
- Lock: dm read with dm_lock=1 while dbg_req stays high. Expect dbg blocked, then a second dm access (dm_lock=0) granted before dbg, then dbg granted.
- Reset mid-write: rst=0 asserted during ACCESS of a dm write. Expect mem_we, dm_gnt and busy to drop at once, state IDLE, locked=0, and rdata=0 after release.
- Idle: no requests for 20 cycles. Expect busy=0, mem_we=0, and all gnt and rvalid at 0.
